// File: rtl/cla_share_arbiter.sv
// Round-robin sequencer that shares one external W-bit add/sub unit among N_REQ requesters.
// Each accepted request runs IDLE -> CALC -> RESP, and its result is returned on a valid/ready handshake.
module cla_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 16,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_sub,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [W-1:0]       rsp_data,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    output logic               add_cin,
    input  logic [W-1:0]       add_sum,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [PTR_W-1:0] rr_ptr_r;
    logic [PTR_W-1:0] owner_r;
    logic [PTR_W-1:0] grant_s;
    logic [PTR_W-1:0] next_ptr_s;
    logic [PTR_W-1:0] idx_s;
    logic             hit_s;
    logic             found_s;
    logic [W-1:0]     add_a_r;
    logic [W-1:0]     add_b_r;
    logic             add_cin_r;
    logic [W-1:0]     rsp_data_r;

    // Round-robin search: first valid requester at rr_ptr, rr_ptr+1, ... modulo N_REQ
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s   = PTR_W'((int'(rr_ptr_r) + k) % N_REQ);
            hit_s   = ~found_s & req_valid[idx_s];
            grant_s = hit_s ? idx_s : grant_s;
            found_s = found_s | hit_s;
        end
        next_ptr_s = (int'(grant_s) == N_REQ - 1) ? '0 : PTR_W'(int'(grant_s) + 1);
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nxt_s = CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: state_nxt_s = RESP;
            RESP: begin
                if (rsp_ready[owner_r]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state; the grant is only offered in IDLE
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if ((state_r == IDLE) && found_s) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
        if (state_r == RESP) begin
            rsp_valid[owner_r] = 1'b1;
        end else begin
            rsp_valid = '0;
        end
        busy = (state_r != IDLE);
    end

    // State, pointer, operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            owner_r    <= '0;
            add_a_r    <= '0;
            add_b_r    <= '0;
            add_cin_r  <= 1'b0;
            rsp_data_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        add_a_r   <= req_a[grant_s*W +: W];
                        add_b_r   <= req_b[grant_s*W +: W];
                        add_cin_r <= req_sub[grant_s];
                        owner_r   <= grant_s;
                        rr_ptr_r  <= next_ptr_s;
                    end
                end
                // Adder inputs were stable for the whole CALC cycle, so the sum is settled
                CALC: rsp_data_r <= add_sum;
                default: begin
                end
            endcase
        end
    end

    assign add_a    = add_a_r;
    assign add_b    = add_b_r;
    assign add_cin  = add_cin_r;
    assign rsp_data = rsp_data_r;

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Scoreboard bench for cla_share_arbiter with a behavioural stand-in for the shared adder.
// Stimulus pushes expected (owner, result) pairs, and a negedge monitor pops and compares them on each response handshake.
module tb_cla_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_sub;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [15:0] rsp_data;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        busy;

    typedef struct {
        int          id;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   exp_grant_q[$];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    always #5 clk = ~clk;

    assign add_sum = add_a + (add_cin ? ~add_b : add_b) + {15'd0, add_cin};

    cla_share_arbiter #(.N_REQ(4), .W(16), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_step();
        exp_t e;
        logic [3:0] oh;
        if ((rsp_valid & rsp_ready) != 4'd0) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e  = sb_q.pop_front();
                oh = 4'b0001 << e.id;
                check("rsp_owner", 32'(rsp_valid), 32'(oh));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
    endtask

    always @(negedge clk) mon_step();

    task automatic set_op(input int id, input logic [15:0] a, input logic [15:0] b, input logic s);
        req_a[id*16 +: 16] = a;
        req_b[id*16 +: 16] = b;
        req_sub[id]        = s;
    endtask

    task automatic push(input int id, input logic [15:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_add_a"}, 32'(add_a), 32'd0);
        check({tag, "_add_b"}, 32'(add_b), 32'd0);
        check({tag, "_add_cin"}, 32'(add_cin), 32'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'd0;
        @(posedge clk);
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One lone request; checks grant, CALC-cycle operands and response latency
    task automatic single_op(input int id, input logic [15:0] a, input logic [15:0] b,
                             input logic s, input logic [15:0] exp_d);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        set_op(id, a, b, s);
        push(id, exp_d);
        req_valid = oh;
        @(negedge clk);
        check("single_grant", 32'(req_ready), 32'(oh));
        @(posedge clk);
        #1 req_valid = 4'd0;
        @(negedge clk);
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_rsp_valid", 32'(rsp_valid), 32'd0);
        check("calc_add_a", 32'(add_a), 32'(a));
        check("calc_add_b", 32'(add_b), 32'(b));
        check("calc_add_cin", 32'(add_cin), 32'(s));
        @(negedge clk);
        check("resp_at_t2", 32'(rsp_valid), 32'(oh));
        @(posedge clk);
        #1;
    endtask

    // Hold a request mask and check each grant against exp_grant_q and the 3-cycle spacing
    task automatic hold_run(input logic [3:0] mask, input int n);
        int         cycles;
        int         id;
        logic [3:0] oh;
        req_valid = mask;
        for (int g = 0; g < n; g++) begin
            id = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : 0;
            oh = 4'b0001 << id;
            @(negedge clk);
            cycles = 1;
            while (req_ready == 4'd0 && cycles < 12) begin
                @(negedge clk);
                cycles++;
            end
            check("grant_order", 32'(req_ready), 32'(oh));
            if (g > 0) begin
                check("grant_spacing", 32'(cycles), 32'd3);
            end
            @(posedge clk);
            #1;
        end
        req_valid = 4'd0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'd0;
        req_a     = 64'd0;
        req_b     = 64'd0;
        req_sub   = 4'd0;
        rsp_ready = 4'hF;
        #2;
        do_reset();

        single_op(0, 16'h0005, 16'h0003, 1'b0, 16'h0008);
        single_op(1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE);
        single_op(3, 16'hFFFF, 16'h0001, 1'b0, 16'h0000);

        do_reset();
        set_op(0, 16'h1000, 16'h0234, 1'b0);
        set_op(1, 16'h0100, 16'h0001, 1'b1);
        set_op(2, 16'h8000, 16'h8000, 1'b0);
        set_op(3, 16'h0000, 16'h0001, 1'b1);
        push(0, 16'h1234); push(1, 16'h00FF); push(2, 16'h0000); push(3, 16'hFFFF); push(0, 16'h1234);
        exp_grant_q = '{0, 1, 2, 3, 0};
        hold_run(4'b1111, 5);

        single_op(2, 16'h0010, 16'h0001, 1'b1, 16'h000F);
        push(3, 16'hFFFF); push(0, 16'h1234);
        exp_grant_q = '{3, 0};
        hold_run(4'b1001, 2);
        push(2, 16'h000F); push(0, 16'h1234);
        exp_grant_q = '{2, 0};
        hold_run(4'b0101, 2);

        set_op(1, 16'h1234, 16'h1111, 1'b0);
        rsp_ready = 4'b1101;
        push(1, 16'h2345);
        push(0, 16'h1234);
        req_valid = 4'b0010;
        @(negedge clk);
        check("stall_grant", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1 req_valid = 4'b0001;
        @(negedge clk);
        check("stall_calc_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", 32'(rsp_valid), 32'h2);
            check("stall_rsp_data", 32'(rsp_data), 32'h2345);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1 rsp_ready = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("after_stall_grant", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = 4'd0;
        repeat (2) @(posedge clk);
        #1;

        set_op(2, 16'h4444, 16'h1111, 1'b1);
        req_valid = 4'b0100;
        @(negedge clk);
        check("pre_abort_grant", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1 req_valid = 4'd0;
        #2 rst_n = 1'b0;
        #1 check_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        push(0, 16'h1234); push(3, 16'hFFFF);
        exp_grant_q = '{0, 3};
        hold_run(4'b1001, 2);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
